// File: rtl/prng_iom.sv
// prng_iom: xorshift32 pseudo-random number generator on the MicroBlaze MCS IO bus.
// Register map (word decode of io_address[11:2]):
//    0x000 SEED  read/write, byte-lane writable; a write also restarts the generator
//    0x004 RAND  read-only; every read advances the generator and returns the new value
//    other       read as zero, writes ignored
// Every accepted transaction is acknowledged exactly one cycle after io_addr_strobe.
module prng_iom #(
   parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        io_addr_strobe,
   input  logic        io_read_strobe,
   input  logic        io_write_strobe,
   input  logic [11:0] io_address,
   input  logic [3:0]  io_byte_enable,
   input  logic [31:0] io_write_data,
   output logic [31:0] io_read_data,
   output logic        io_ready
);

   // Word indices within the peripheral window.
   localparam logic [9:0] WORD_SEED = 10'd0;
   localparam logic [9:0] WORD_RAND = 10'd1;

   // One xorshift32 step; shifts are logical and truncate to 32 bits.
   function automatic logic [31:0] xorshift32(input logic [31:0] x);
      logic [31:0] t;
      t = x ^ (x << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   logic [31:0] seed_q,  seed_d;
   logic [31:0] state_q, state_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;

   logic [9:0]  word_addr;
   logic        hit_seed;
   logic        hit_rand;
   logic        do_write;
   logic        do_read;
   logic [31:0] merged_seed;
   logic [31:0] next_rand;

   // The byte offset within a word carries no meaning for this block.
   logic unused_addr_bits;
   assign unused_addr_bits = ^io_address[1:0];

   assign word_addr = io_address[11:2];
   assign hit_seed  = (word_addr == WORD_SEED);
   assign hit_rand  = (word_addr == WORD_RAND);

   // A write wins when both qualifiers are set; the read side is then suppressed.
   assign do_write  = io_addr_strobe & io_write_strobe;
   assign do_read   = io_addr_strobe & io_read_strobe & ~io_write_strobe;

   assign next_rand = xorshift32(state_q);

   // Merge write data into the current seed lane by lane.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      merged_seed = seed_q;
      for (int i = 0; i < 4; i++) begin
         if (io_byte_enable[i]) begin
            merged_seed[8*i +: 8] = io_write_data[8*i +: 8];
         end
      end
   end

   // Next-state for seed, generator state and read data.
   always_comb begin
      seed_d  = seed_q;
      state_d = state_q;
      rdata_d = rdata_q;
      ready_d = io_addr_strobe;

      if (do_write) begin
         if (hit_seed) begin
            seed_d = merged_seed;
            // A zero state would lock xorshift32 at zero forever, so substitute the reset seed.
            state_d = (merged_seed == 32'h0) ? RESET_SEED : merged_seed;
         end
      end else if (do_read) begin
         if (hit_seed) begin
            rdata_d = seed_q;
         end else if (hit_rand) begin
            state_d = next_rand;
            rdata_d = next_rand;
         end else begin
            rdata_d = 32'h0;
         end
      end
   end

   // Register all state; reset clears any pending acknowledge immediately.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         seed_q  <= RESET_SEED;
         state_q <= RESET_SEED;
         rdata_q <= 32'h0;
         ready_q <= 1'b0;
      end else begin
         seed_q  <= seed_d;
         state_q <= state_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
      end
   end

   assign io_read_data = rdata_q;
   assign io_ready     = ready_q;

endmodule

// File: tb/tb_prng_iom.sv
// Self-checking bench for prng_iom: an IO-bus master model, a cycle-level
// behavioural reference of the register map, and directed scenarios.
module tb_prng_iom;

   logic        clk;
   logic        rst;
   logic        io_addr_strobe;
   logic        io_read_strobe;
   logic        io_write_strobe;
   logic [11:0] io_address;
   logic [3:0]  io_byte_enable;
   logic [31:0] io_write_data;
   logic [31:0] io_read_data;
   logic        io_ready;

   int n_checks = 0;
   int n_errors = 0;

   prng_iom #(.RESET_SEED(32'h0000_0001)) dut (
      .clk             (clk),
      .rst             (rst),
      .io_addr_strobe  (io_addr_strobe),
      .io_read_strobe  (io_read_strobe),
      .io_write_strobe (io_write_strobe),
      .io_address      (io_address),
      .io_byte_enable  (io_byte_enable),
      .io_write_data   (io_write_data),
      .io_read_data    (io_read_data),
      .io_ready        (io_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference xorshift32 written as arithmetic on unsigned integers.
   function automatic logic [31:0] ref_step(input logic [31:0] x);
      longint unsigned v;
      v = x;
      v = (v ^ (v * 64'd8192)) % 64'h1_0000_0000;
      v = v ^ (v / 64'd131072);
      v = (v ^ (v * 64'd32)) % 64'h1_0000_0000;
      return v[31:0];
   endfunction

   // ---------------- behavioural reference of the peripheral ----------------
   logic [31:0] m_seed, m_state, m_rdata;
   logic        m_ready;

   always @(posedge clk or negedge rst) begin
      logic [31:0] mask, merged;
      if (!rst) begin
         m_seed  = 32'h1;
         m_state = 32'h1;
         m_rdata = 32'h0;
         m_ready = 1'b0;
      end else begin
         m_ready = io_addr_strobe;
         if (io_addr_strobe && io_write_strobe) begin
            if (io_address / 4 == 0) begin
               mask   = {{8{io_byte_enable[3]}}, {8{io_byte_enable[2]}},
                         {8{io_byte_enable[1]}}, {8{io_byte_enable[0]}}};
               merged = (io_write_data & mask) | (m_seed & ~mask);
               m_seed  = merged;
               m_state = (merged == 0) ? 32'h1 : merged;
            end
         end else if (io_addr_strobe && io_read_strobe) begin
            case (io_address / 4)
               0:       m_rdata = m_seed;
               1:       begin m_state = ref_step(m_state); m_rdata = m_state; end
               default: m_rdata = 32'h0;
            endcase
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   int          ack_cnt = 0;
   logic [31:0] ack_q[$];
   always @(negedge clk) begin
      check("ready", {31'h0, io_ready}, {31'h0, m_ready});
      check("rdata", io_read_data, m_rdata);
      if (io_ready === 1'b1) begin
         ack_cnt++;
         ack_q.push_back(io_read_data);
      end
   end

   // ---------------- IO bus master model ----------------
   // Present one transaction now; it is accepted on the next rising edge.
   task automatic issue(input logic wr, input logic rd, input logic [11:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
      io_addr_strobe  = 1'b1;
      io_write_strobe = wr;
      io_read_strobe  = rd;
      io_address      = addr;
      io_byte_enable  = be;
      io_write_data   = data;
      @(posedge clk);
      #1;
      io_addr_strobe  = 1'b0;
      io_write_strobe = 1'b0;
      io_read_strobe  = 1'b0;
   endtask

   task automatic io_write(input logic [11:0] addr, input logic [3:0] be, input logic [31:0] data);
      issue(1'b1, 1'b0, addr, be, data);
      @(negedge clk);
      check("wr_ack", {31'h0, io_ready}, 32'h1);
   endtask

   task automatic io_read(input logic [11:0] addr, output logic [31:0] data);
      issue(1'b0, 1'b1, addr, 4'h0, 32'h0);
      @(negedge clk);
      check("rd_ack", {31'h0, io_ready}, 32'h1);
      data = io_read_data;
   endtask

   logic [31:0] d;
   logic [31:0] a1[4], a2[4], b1[4], b2[4];
   logic [31:0] exp_v;
   int          acks_before;

   initial begin
      rst = 1'b0;
      io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
      io_address = 12'h0; io_byte_enable = 4'h0; io_write_data = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("reset_rdata", io_read_data, 32'h0);
      check("reset_ready", {31'h0, io_ready}, 32'h0);

      // Reset values.
      io_read(12'h000, d); check("seed_after_reset", d, 32'h0000_0001);
      io_read(12'h004, d); check("rand_after_reset", d, 32'h0004_2021);

      // Zero seed: stored as zero, generator restarts from the reset seed.
      io_write(12'h000, 4'hF, 32'h0);
      io_read(12'h000, d); check("seed_zero", d, 32'h0);
      io_read(12'h004, d); check("rand_zero_subst", d, 32'h0004_2021);

      // Deterministic restart.
      io_write(12'h000, 4'hF, 32'hDEAD_BEEF);
      io_read(12'h000, d); check("seed_deadbeef_1", d, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) io_read(12'h004, a1[i]);
      io_write(12'h000, 4'hF, 32'hDEAD_BEEF);
      io_read(12'h000, d); check("seed_deadbeef_2", d, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) io_read(12'h004, a2[i]);
      exp_v = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         exp_v = ref_step(exp_v);
         check("seq_deadbeef", a1[i], exp_v);
         check("seq_repeat", a2[i], a1[i]);
         check("seq_nonzero", {31'h0, a1[i] != 32'h0}, 32'h1);
         for (int j = 0; j < i; j++)
            check("seq_distinct", {31'h0, a1[i] != a1[j]}, 32'h1);
      end

      // Byte-lane seed write.
      io_write(12'h000, 4'hF, 32'h0);
      io_write(12'h000, 4'b0001, 32'hFFFF_FFFF);
      io_read(12'h000, d); check("seed_lane0", d, 32'h0000_00FF);
      for (int i = 0; i < 4; i++) io_read(12'h004, b1[i]);
      io_write(12'h000, 4'hF, 32'h0000_00FF);
      for (int i = 0; i < 4; i++) io_read(12'h004, b2[i]);
      for (int i = 0; i < 4; i++) check("lane_vs_full", b1[i], b2[i]);

      // Unmapped accesses: acknowledged, read zero, state untouched.
      io_read(12'h008, d); check("unmapped_read", d, 32'h0);
      io_write(12'h00C, 4'hF, 32'h1234_5678);
      io_read(12'h004, d); check("rand_after_unmapped", d, ref_step(b2[3]));

      // Both qualifiers: write wins, read data held.
      exp_v = io_read_data;
      issue(1'b1, 1'b1, 12'h000, 4'hF, 32'h0000_0001);
      @(negedge clk);
      check("rw_ack", {31'h0, io_ready}, 32'h1);
      check("rw_rdata_held", io_read_data, exp_v);
      @(negedge clk);
      check("rw_single_ack", {31'h0, io_ready}, 32'h0);

      // Back-to-back RAND reads from seed 1, next strobe in each ready cycle.
      ack_q.delete();
      acks_before = ack_cnt;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 12'h004, 4'h0, 32'h0);
      repeat (2) @(negedge clk);
      check("b2b_ack_count", ack_cnt - acks_before, 32'd4);
      if (ack_q.size() >= 2) begin
         check("b2b_first", ack_q[0], 32'h0004_2021);
         check("b2b_second", ack_q[1], 32'h0408_0601);
      end else begin
         check("b2b_queue_size", ack_q.size(), 32'd4);
      end

      // Reset asserted while a read acknowledge is in flight.
      issue(1'b0, 1'b1, 12'h004, 4'h0, 32'h0);
      acks_before = ack_cnt;
      #1 rst = 1'b0;
      #1 check("ready_dropped", {31'h0, io_ready}, 32'h0);
      check("rdata_cleared", io_read_data, 32'h0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("no_ack_after_reset", ack_cnt - acks_before, 32'd0);
      io_read(12'h000, d); check("seed_after_midreset", d, 32'h0000_0001);
      io_read(12'h004, d); check("rand_after_midreset", d, 32'h0004_2021);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Watchdog: the directed flow is short; anything longer is a hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
